// File: rtl/steer_quad_gen.sv
// -----------------------------------------------------------------------------
// steer_quad_gen
//
// Turns level-style steer-left / steer-right requests into a quadrature pair
// that emulates a rotary steering encoder.  While a direction is held the
// encoder "spins": the first step is issued right away.  After that the step
// period starts at SLOW_DIV cycles and shrinks by RAMP_DEC after every step,
// down to a floor of FAST_DIV cycles.  Releasing the request stops the encoder
// where it is.  Holding both requests counts as no request.  Reversing the
// direction gives an immediate step the other way and restarts the ramp.
//
// Parameters
//   SLOW_DIV  step period (cycles) at the start of a press
//   FAST_DIV  minimum step period (cycles), 2 <= FAST_DIV <= SLOW_DIV
//   RAMP_DEC  cycles removed from the period after each step
//
// Ports
//   clk_sys  in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   left     in   steer-left request level (asynchronous)
//   right    in   steer-right request level (asynchronous)
//   steer    out  [1] = phase A, [0] = phase B (Gray sequence)
//   moving   out  high while a direction is being driven
//   dir      out  direction of the last step: 1 = right, 0 = left
// -----------------------------------------------------------------------------
module steer_quad_gen #(
  parameter int unsigned SLOW_DIV = 22500,
  parameter int unsigned FAST_DIV = 5625,
  parameter int unsigned RAMP_DEC = 1125
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  output logic [1:0] steer,
  output logic       moving,
  output logic       dir
);

  localparam int unsigned PW        = $clog2(SLOW_DIV + 1);
  localparam logic [PW-1:0] SLOW_P  = PW'(SLOW_DIV);
  localparam logic [PW-1:0] SLOW_M1 = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] FAST_P  = PW'(FAST_DIV);
  // Periods below this value would drop under FAST_DIV after one decrement.
  localparam int unsigned SAT_FLOOR = FAST_DIV + RAMP_DEC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_R = 2'd1,
    RUN_L = 2'd2
  } state_t;

  // Next period after a step: period - RAMP_DEC, clamped at FAST_DIV.
  // The comparison is done at 32 bits so the subtraction can never wrap.
  function automatic logic [PW-1:0] sat_period(input logic [PW-1:0] p);
    logic [PW-1:0] res;
    if (32'(p) >= SAT_FLOOR) res = PW'(32'(p) - RAMP_DEC);
    else                     res = FAST_P;
    return res;
  endfunction

  // One quadrature step.  Right: 00 -> 01 -> 11 -> 10 -> 00; left is the
  // reverse walk, so exactly one bit changes either way.
  function automatic logic [1:0] gray_step(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    case (ph)
      2'b00:   nxt = fwd ? 2'b01 : 2'b10;
      2'b01:   nxt = fwd ? 2'b11 : 2'b00;
      2'b11:   nxt = fwd ? 2'b10 : 2'b01;
      default: nxt = fwd ? 2'b00 : 2'b11;
    endcase
    return nxt;
  endfunction

  // Stage p0/p1: two-flop synchronizers for the asynchronous request levels
  logic left_p0, left_p1;
  logic right_p0, right_p1;
  logic sl, sr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      left_p0  <= 1'b0;
      left_p1  <= 1'b0;
      right_p0 <= 1'b0;
      right_p1 <= 1'b0;
    end else begin
      left_p0  <= left;
      left_p1  <= left_p0;
      right_p0 <= right;
      right_p1 <= right_p0;
    end
  end

  assign sl = left_p1;
  assign sr = right_p1;

  // Stage p2: request decode, FSM, step timer and registered outputs
  logic req_r, req_l;
  assign req_r = sr & ~sl;
  assign req_l = sl & ~sr;

  state_t        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [1:0]    steer_q, steer_d;
  logic          dir_q, dir_d;
  logic          moving_q, moving_d;

  logic          do_entry;
  logic          do_tick;
  logic          step_right;
  logic [PW-1:0] period_next;

  assign period_next = sat_period(period_q);

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    steer_d    = steer_q;
    dir_d      = dir_q;
    do_entry   = 1'b0;
    do_tick    = 1'b0;
    step_right = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_r) begin
          state_d    = RUN_R;
          do_entry   = 1'b1;
          step_right = 1'b1;
        end else if (req_l) begin
          state_d    = RUN_L;
          do_entry   = 1'b1;
        end
      end
      RUN_R: begin
        if (req_r) begin
          do_tick    = 1'b1;
          step_right = 1'b1;
        end else if (req_l) begin
          // Reversal is treated exactly like a fresh press to the left.
          state_d    = RUN_L;
          do_entry   = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN_L: begin
        if (req_l) begin
          do_tick    = 1'b1;
        end else if (req_r) begin
          state_d    = RUN_R;
          do_entry   = 1'b1;
          step_right = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_entry) begin
      // Step immediately; the countdown is loaded with period-1 so the next
      // step lands exactly SLOW_DIV cycles later.
      steer_d  = gray_step(steer_q, step_right);
      dir_d    = step_right;
      period_d = SLOW_P;
      cnt_d    = SLOW_M1;
    end else if (do_tick) begin
      if (cnt_q == '0) begin
        steer_d  = gray_step(steer_q, step_right);
        dir_d    = step_right;
        period_d = period_next;
        cnt_d    = period_next - PW'(1);
      end else begin
        cnt_d    = cnt_q - PW'(1);
      end
    end

    moving_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= SLOW_P;
      cnt_q    <= '0;
      steer_q  <= 2'b00;
      dir_q    <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      steer_q  <= steer_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
    end
  end

  assign steer  = steer_q;
  assign moving = moving_q;
  assign dir    = dir_q;

endmodule

// File: tb/tb_steer_quad_gen.sv
// -----------------------------------------------------------------------------
// tb_steer_quad_gen
//
// Bench for steer_quad_gen with SLOW_DIV=16, FAST_DIV=4, RAMP_DEC=4.
// A behavioural model (integer phase index, period and countdown in plain
// arithmetic, synchronizer as a two-deep delay) predicts steer/moving/dir every
// cycle.  Directed scenarios additionally check absolute step times and codes
// worked out by hand; a randomized phase with 1-cycle glitches checks Gray
// transitions and the minimum step gap.
// -----------------------------------------------------------------------------
module tb_steer_quad_gen;

  localparam int SLOW = 16;
  localparam int FAST = 4;
  localparam int RAMP = 4;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       left    = 1'b0;
  logic       right   = 1'b0;
  logic [1:0] steer;
  logic       moving;
  logic       dir;

  steer_quad_gen #(
    .SLOW_DIV(SLOW),
    .FAST_DIV(FAST),
    .RAMP_DEC(RAMP)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .steer  (steer),
    .moving (moving),
    .dir    (dir)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model state
  int gray_tab[4] = '{0, 1, 3, 2};
  int m_s1l = 0, m_s1r = 0, m_s2l = 0, m_s2r = 0;
  int m_mode = 0;            // 0 idle, 1 right, 2 left
  int m_per  = SLOW;
  int m_cnt  = 0;
  int m_ph   = 0;            // index into gray_tab
  int m_dir  = 0;
  int m_mov  = 0;
  int m_tick = 0;            // last edge produced a timed (non-entry) step

  task automatic model_step(input int go_right);
    m_ph  = go_right ? (m_ph + 1) % 4 : (m_ph + 3) % 4;
    m_dir = go_right;
  endtask

  task automatic model_edge();
    int req;
    m_tick = 0;
    if (reset) begin
      m_s1l = 0; m_s1r = 0; m_s2l = 0; m_s2r = 0;
      m_mode = 0; m_per = SLOW; m_cnt = 0; m_ph = 0; m_dir = 0;
    end else begin
      req = (m_s2r && !m_s2l) ? 1 : (m_s2l && !m_s2r) ? 2 : 0;
      if (req == 0) begin
        m_mode = 0;
      end else if (req != m_mode) begin
        m_mode = req;
        model_step(req == 1);
        m_per = SLOW;
        m_cnt = SLOW - 1;
      end else if (m_cnt == 0) begin
        model_step(req == 1);
        m_per  = (m_per - RAMP > FAST) ? m_per - RAMP : FAST;
        m_cnt  = m_per - 1;
        m_tick = 1;
      end else begin
        m_cnt--;
      end
      m_s2l = m_s1l; m_s2r = m_s1r;
      m_s1l = int'(left); m_s1r = int'(right);
    end
    m_mov = (m_mode != 0);
  endtask

  // Transition recording, times relative to start_rec()
  int         t_rel = 0;
  int         last_t = 0;
  int         ch_t[$];
  int         ch_v[$];
  logic [1:0] prev_steer = 2'b00;
  bit         rand_mode = 1'b0;

  task automatic start_rec();
    t_rel  = 0;
    last_t = 0;
    ch_t.delete();
    ch_v.delete();
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    model_edge();
    #1;
    t_rel++;
    check("steer", int'(steer), gray_tab[m_ph]);
    check("moving", int'(moving), m_mov);
    check("dir", int'(dir), m_dir);
    if (steer != prev_steer) begin
      ch_t.push_back(t_rel);
      ch_v.push_back(int'(steer));
      if (rand_mode) begin
        check("gray_1bit", $countones(steer ^ prev_steer), 1);
        if (m_tick != 0) check("gap_ge_fast", int'((t_rel - last_t) >= FAST), 1);
      end
      last_t = t_rel;
    end
    prev_steer = steer;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    left  = 1'b0;
    right = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic exp_change(input int idx, input int t, input int v);
    if (idx < ch_t.size()) begin
      check($sformatf("chg%0d_time", idx), ch_t[idx], t);
      check($sformatf("chg%0d_code", idx), ch_v[idx], v);
    end else begin
      check($sformatf("chg%0d_present", idx), ch_t.size(), idx + 1);
    end
  endtask

  initial begin
    int mov_cnt;

    // Reset state, with right already held during reset
    right = 1'b1;
    repeat (3) cyc();
    check("rst_steer", int'(steer), 0);
    check("rst_moving", int'(moving), 0);
    check("rst_dir", int'(dir), 0);

    // Hold right from reset release: ramp 16,12,8,4,...
    reset = 1'b0;
    start_rec();
    repeat (45) cyc();
    check("right_n_chg", ch_t.size(), 5);
    exp_change(0, 3, 1);
    exp_change(1, 19, 3);
    exp_change(2, 31, 2);
    exp_change(3, 39, 0);
    exp_change(4, 43, 1);
    check("right_dir", int'(dir), 1);
    check("right_moving", int'(moving), 1);

    // Hold left 40 cycles, then release
    do_reset(2);
    reset = 1'b0;
    left  = 1'b1;
    start_rec();
    repeat (40) cyc();
    left = 1'b0;
    repeat (2) cyc();
    check("left_moving_t42", int'(moving), 1);
    cyc();
    check("left_moving_t43", int'(moving), 0);
    repeat (20) cyc();
    check("left_n_chg", ch_t.size(), 4);
    exp_change(0, 3, 2);
    exp_change(1, 19, 3);
    exp_change(2, 31, 1);
    exp_change(3, 39, 0);
    check("left_dir", int'(dir), 0);

    // Both pressed: nothing happens
    do_reset(2);
    reset = 1'b0;
    left  = 1'b1;
    right = 1'b1;
    start_rec();
    mov_cnt = 0;
    repeat (100) begin
      cyc();
      if (moving) mov_cnt++;
    end
    check("both_n_chg", ch_t.size(), 0);
    check("both_moving_cycles", mov_cnt, 0);

    // Right into fast phase, then reverse to left
    do_reset(2);
    reset = 1'b0;
    right = 1'b1;
    start_rec();
    repeat (45) cyc();
    right = 1'b0;
    left  = 1'b1;
    repeat (21) cyc();
    check("rev_n_chg", ch_t.size(), 8);
    exp_change(0, 3, 1);
    exp_change(1, 19, 3);
    exp_change(2, 31, 2);
    exp_change(3, 39, 0);
    exp_change(4, 43, 1);
    exp_change(5, 47, 3);
    exp_change(6, 48, 1);
    exp_change(7, 64, 0);
    check("rev_dir", int'(dir), 0);

    // One-cycle reset mid-press at period 8
    do_reset(2);
    reset = 1'b0;
    left  = 1'b0;
    right = 1'b1;
    start_rec();
    repeat (34) cyc();
    reset = 1'b1;
    cyc();
    check("midrst_steer", int'(steer), 0);
    check("midrst_moving", int'(moving), 0);
    reset = 1'b0;
    repeat (21) cyc();
    check("midrst_n_chg", ch_t.size(), 6);
    exp_change(0, 3, 1);
    exp_change(1, 19, 3);
    exp_change(2, 31, 2);
    exp_change(3, 35, 0);
    exp_change(4, 38, 1);
    exp_change(5, 54, 3);

    // Randomized holds with 1-cycle glitches
    do_reset(2);
    reset = 1'b0;
    start_rec();
    rand_mode = 1'b1;
    repeat (40) begin
      int base;
      int len;
      base = $urandom_range(0, 3);
      len  = $urandom_range(1, 80);
      for (int i = 0; i < len; i++) begin
        logic bl;
        logic br;
        bl = (base == 2) || (base == 3);
        br = (base == 1) || (base == 3);
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 1) bl = ~bl;
          else                           br = ~br;
        end
        left  = bl;
        right = br;
        cyc();
      end
    end
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
